// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard front end: synchronises and deglitches the raw lines, deserialises
// 11-bit frames and folds E0/F0/E1 prefixes into single {toggle, pressed, extended, code} events.
//
// state     | meaning
// ----------+-------------------------------------------------
// P_IDLE    | no prefix pending
// P_EXT     | E0 seen, next code is extended
// P_BRK     | F0 seen, next code is a release
// P_EXT_BRK | E0 F0 seen, next code is an extended release
// P_SKIP    | swallowing the Pause sequence (skip_cnt bytes left)
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000
) (
    input  logic        clk_25,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        P_IDLE,
        P_EXT,
        P_BRK,
        P_EXT_BRK,
        P_SKIP
    } pstate_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [7:0]    clk_cnt;
    logic [7:0]    data_cnt;
    logic          clk_filt;
    logic          data_filt;
    logic          clk_filt_d;
    logic          fall;

    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmr;
    logic          stop_edge;
    logic          byte_ok;
    logic          byte_bad;
    logic          timeout;

    pstate_t       state;
    pstate_t       state_nx;
    logic [2:0]    skip_cnt;
    logic [2:0]    skip_nx;
    logic          is_code;
    logic          emit;
    logic          pressed;
    logic          extended;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // A line only follows its synchronised input after FILTER_LEN identical samples.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            clk_filt   <= 1'b1;
            data_filt  <= 1'b1;
            clk_filt_d <= 1'b1;
            clk_cnt    <= '0;
            data_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == 8'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + 8'd1;
            end
            if (data_sync[1] == data_filt) begin
                data_cnt <= '0;
            end else if (data_cnt == 8'(FILTER_LEN - 1)) begin
                data_filt <= data_sync[1];
                data_cnt  <= '0;
            end else begin
                data_cnt <= data_cnt + 8'd1;
            end
        end
    end

    assign fall      = clk_filt_d & ~clk_filt;
    assign stop_edge = fall && (bit_cnt == 4'd10);
    assign byte_ok   = stop_edge && data_filt && (^{shift, par_bit});
    assign byte_bad  = stop_edge && !byte_ok;
    assign timeout   = (bit_cnt != 4'd0) && !fall && (tmr == '0);
    assign busy      = (bit_cnt != 4'd0);

    always_ff @(posedge clk_25) begin
        if (reset) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tmr     <= '0;
        end else if (fall) begin
            tmr <= TW'(TIMEOUT - 1);
            case (bit_cnt)
                4'd0:  if (!data_filt) bit_cnt <= 4'd1;
                4'd9: begin
                    par_bit <= data_filt;
                    bit_cnt <= 4'd10;
                end
                4'd10: bit_cnt <= 4'd0;
                default: begin
                    shift   <= {data_filt, shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            endcase
        end else if (timeout) begin
            bit_cnt <= '0;
        end else if ((bit_cnt != 4'd0) && (tmr != '0)) begin
            tmr <= tmr - TW'(1);
        end
    end

    assign is_code = !(shift inside {8'hE0, 8'hE1, 8'hF0, 8'hAA, 8'hEE,
                                     8'hFA, 8'hFE, 8'h00, 8'hFF});

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state     <= P_IDLE;
            skip_cnt  <= '0;
            ps2_key   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            skip_cnt  <= skip_nx;
            frame_err <= byte_bad || timeout;
            if (emit) ps2_key <= {~ps2_key[10], pressed, extended, shift};
        end
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        if (byte_bad) begin
            state_nx = P_IDLE;
            skip_nx  = '0;
        end else if (timeout) begin
            state_nx = P_IDLE;
        end else if (byte_ok) begin
            if (skip_cnt != 3'd0) begin
                skip_nx = skip_cnt - 3'd1;
                if (skip_cnt == 3'd1) state_nx = P_IDLE;
            end else begin
                case (shift)
                    8'hE1: begin
                        skip_nx  = 3'd7;
                        state_nx = P_SKIP;
                    end
                    8'hE0: state_nx = P_EXT;
                    8'hF0: begin
                        if (state == P_IDLE)     state_nx = P_BRK;
                        else if (state == P_EXT) state_nx = P_EXT_BRK;
                    end
                    default: state_nx = P_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        emit     = byte_ok && (skip_cnt == 3'd0) && is_code;
        extended = (state == P_EXT) || (state == P_EXT_BRK);
        pressed  = (state == P_IDLE) || (state == P_EXT);
    end

endmodule

// File: doc/ps2_key_encoder.md
# ps2_key_encoder

Converts the raw two-wire PS/2 keyboard interface into the 11-bit `ps2_key` event word that the core's key decoders consume. Bit 10 toggles per event, bit 9 is pressed, bit 8 is extended, and bits 7:0 are the scan code. It sits between the physical keyboard pins and the core's `ps2_key` consumers, and is a drop-in source for the `ps2_key` bus. The block synchronises and deglitches the lines, deserialises 11-bit frames, and resolves the E0/F0/E1 prefix sequences into single events.

## Interface
Parameters:
- `FILTER_LEN`, default 8: number of consecutive equal synchronised samples required before a filtered line changes (range 2..255).
- `TIMEOUT`, default 25000: idle cycles inside a partial frame before that frame is abandoned (1 ms at 25 MHz).

Ports:
- `clk_25` in 1: single clock, 25 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: raw keyboard clock line, asynchronous, idles high.
- `ps2_data` in 1: raw keyboard data line, asynchronous, idles high.
- `ps2_key` out 11: event word {toggle, pressed, extended, code[7:0]}.
- `frame_err` out 1: one-cycle pulse on a parity, stop-bit or timeout error.
- `busy` out 1: high while the bit counter is non-zero, i.e. a frame is in progress.

## Operation
Synchronisation and filtering:
- Both lines pass through 2-FF synchronisers, then a per-line stability counter.
- A filtered line takes the new level only after `FILTER_LEN` consecutive equal samples.
- A falling edge of filtered `ps2_clk` samples filtered `ps2_data`.

Deserialiser:
- Frame is start bit (0), 8 data bits LSB first, odd parity, stop bit (1). The bit counter runs 0..10.
- Start bit = 1: discard silently, counter stays 0, no `frame_err`.
- Parity mismatch, or stop bit = 0: pulse `frame_err`, drop the byte, force the prefix FSM to P_IDLE and clear the skip count.
- Timeout: counter ≠ 0 and no falling edge for `TIMEOUT` cycles. Clear the counter, pulse `frame_err`, set the prefix FSM to P_IDLE.

Prefix FSM. States are P_IDLE, P_EXT, P_BRK, P_EXT_BRK, and P_SKIP (with a 3-bit skip count). Each valid byte is handled as follows:
- Skip count > 0: drop the byte and decrement the count; the state returns to P_IDLE when the count reaches 0.
- `E1`: set skip count = 7, which swallows the 8-byte Pause sequence. No event.
- `E0`: P_IDLE→P_EXT. In P_EXT it stays P_EXT. In P_BRK or P_EXT_BRK it goes to P_EXT.
- `F0`: P_IDLE→P_BRK, P_EXT→P_EXT_BRK, and any other state stays as is.
- `AA`, `EE`, `FA`, `FE`, `00`, `FF` (keyboard responses): drop, go to P_IDLE.
- Any other byte: emit an event and go to P_IDLE.
  - `code` = the byte.
  - `extended` = state ∈ {P_EXT, P_EXT_BRK}.
  - `pressed` = state ∈ {P_IDLE, P_EXT}.
  - `ps2_key[10]` inverts.
  - All 11 bits update in the same cycle.

Reset values:
- `ps2_key` = 0, `frame_err` = 0, `busy` = 0.
- Filtered lines = 1, sync FFs = 1, counters = 0, state P_IDLE.

## Timing
- Input to filtered line: 2 + `FILTER_LEN` cycles.
- Event output: `ps2_key` updates exactly 1 cycle after the cycle in which the stop-bit falling edge is detected.
- `frame_err` is asserted in that same cycle for a bad frame, and exactly 1 cycle for a timeout (cycle `TIMEOUT`+1 after the last edge).
- `busy` rises the cycle after the start-bit edge and falls together with the event or error.
- Reset mid-frame abandons the frame, with no event and no `frame_err`. Any trailing bits are re-framed and recovered by start-bit rejection or by timeout.
- A reset coincident with the stop-bit edge wins: no event is emitted.
- The toggle bit has no back-pressure. Consumers sample on change, and the minimum event spacing is one frame (≥ 11 PS/2 clocks).

## Test plan
- Make code `1C` at a 12.5 kHz PS/2 clock, starting after reset → `ps2_key` = `11'h61C`.
- Break sequence `F0 1C` following that make → `ps2_key` = `11'h01C`, with exactly one change.
- Extended `E0 6B`, then `E0 F0 6B` → `11'h76B`, then `11'h16B`.
- Frame `1C` with a flipped parity bit → `frame_err` high for 1 cycle, `ps2_key` unchanged. A following good `1C` → toggle flips, pressed = 1.
- Glitch pulses on `ps2_clk` of `FILTER_LEN`−1 cycles → no bit sampled, `busy` stays 0. A partial frame of 4 bits → `frame_err` pulse at `TIMEOUT`+1 cycles, `busy` = 0.
- Pause sequence `E1 14 77 E1 F0 14 F0 77`, then `1C` → no event for the Pause bytes, then `ps2_key` = {toggled, 1, 0, `1C`}.
